// File: rtl/axi_pkg.sv
// Shared AXI4 types for the memory responder: burst and response encodings,
// channel FSM states and the burst legality test.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    // Only full-width FIXED or INCR bursts touch memory; WRAP, reserved and narrow are errors.
    function automatic logic burst_legal(input logic [2:0] size, input logic [1:0] burst,
                                         input logic [2:0] beat_size);
        return (size == beat_size) && ((burst == BURST_FIXED) || (burst == BURST_INCR));
    endfunction

endpackage

// File: rtl/axi_mem_dpram.sv
// Word-addressed memory: one byte-enabled write port and one registered read port.
// A read of the word being written in the same cycle returns the old contents.
module axi_mem_dpram #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 256,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic [AW-1:0]           waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    re,
    input  logic [AW-1:0]           raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose so it maps onto block RAM; contents are undefined until written.
    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (we && wbe[b]) begin
                mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 memory-backed slave: independent write and read FSMs over a shared
// word memory, with per-beat range checking and SLVERR for illegal bursts.
module axi_mem_responder
    import axi_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int          ADDR_LSB  = $clog2(DATA_WIDTH / 8);
    localparam int          IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [2:0]  BEAT_SIZE = 3'(ADDR_LSB);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] word);
        return word[ADDR_WIDTH-1:IDX_W] == '0;
    endfunction

    // Holds the address-channel readies low until the first clock after reset.
    logic live;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) live <= 1'b0;
        else        live <= 1'b1;
    end

    // ---------------- write path ----------------
    w_state_e              w_state, w_state_nxt;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_word;
    logic [7:0]            w_len, w_cnt;
    logic                  w_incr, w_legal, w_err;
    logic                  aw_hs, w_hs, b_hs, w_last_beat, w_beat_ok;

    assign awready     = live && (w_state == W_IDLE);
    assign wready      = (w_state == W_DATA);
    assign bvalid      = (w_state == W_RESP);
    assign bid         = w_id;
    assign bresp       = bvalid ? (w_err ? RESP_SLVERR : RESP_OKAY) : RESP_OKAY;
    assign aw_hs       = awvalid && awready;
    assign w_hs        = wvalid && wready;
    assign b_hs        = bvalid && bready;
    assign w_last_beat = (w_cnt == w_len);
    assign w_beat_ok   = w_legal && in_range(w_word);

    // NOTE: the next-state default is assigned before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_state_nxt = W_RESP;
            W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_word  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_incr  <= 1'b0;
            w_legal <= 1'b0;
            w_err   <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            if (aw_hs) begin
                w_id    <= awid;
                w_word  <= awaddr >> ADDR_LSB;
                w_len   <= awlen;
                w_cnt   <= '0;
                w_incr  <= (awburst == BURST_INCR);
                w_legal <= burst_legal(awsize, awburst, BEAT_SIZE);
                w_err   <= 1'b0;
            end else if (w_hs) begin
                // The beat count, not wlast, ends the burst; a wlast mismatch only flags the error.
                if (!w_beat_ok || (wlast != w_last_beat)) w_err <= 1'b1;
                if (!w_last_beat) begin
                    w_cnt <= w_cnt + 8'd1;
                    if (w_incr) w_word <= w_word + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // ---------------- read path ----------------
    r_state_e              r_state, r_state_nxt;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_word, r_word_nxt, ar_word;
    logic [7:0]            r_len, r_cnt;
    logic                  r_incr, r_legal, r_ok;
    logic                  ar_hs, r_hs, r_last_beat;
    logic                  mem_re;
    logic [IDX_W-1:0]      mem_raddr;
    logic [DATA_WIDTH-1:0] mem_q;

    assign arready     = live && (r_state == R_IDLE);
    assign rvalid      = (r_state == R_DATA);
    assign ar_hs       = arvalid && arready;
    assign r_hs        = rvalid && rready;
    assign r_last_beat = (r_cnt == r_len);
    assign ar_word     = araddr >> ADDR_LSB;
    assign r_word_nxt  = r_incr ? r_word + ADDR_WIDTH'(1) : r_word;
    assign rid         = r_id;
    assign rlast       = rvalid && r_last_beat;
    assign rresp       = rvalid ? (r_ok ? RESP_OKAY : RESP_SLVERR) : RESP_OKAY;
    assign rdata       = (rvalid && r_ok) ? mem_q : '0;

    // The memory output register only advances on accept, so stalled beats hold their data.
    assign mem_re    = ar_hs || (r_hs && !r_last_beat);
    assign mem_raddr = ar_hs ? ar_word[IDX_W-1:0] : r_word_nxt[IDX_W-1:0];

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
            R_DATA:  if (r_hs && r_last_beat) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_word  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_incr  <= 1'b0;
            r_legal <= 1'b0;
            r_ok    <= 1'b0;
        end else begin
            r_state <= r_state_nxt;
            if (ar_hs) begin
                r_id    <= arid;
                r_word  <= ar_word;
                r_len   <= arlen;
                r_cnt   <= '0;
                r_incr  <= (arburst == BURST_INCR);
                r_legal <= burst_legal(arsize, arburst, BEAT_SIZE);
                r_ok    <= burst_legal(arsize, arburst, BEAT_SIZE) && in_range(ar_word);
            end else if (r_hs && !r_last_beat) begin
                r_cnt  <= r_cnt + 8'd1;
                r_word <= r_word_nxt;
                r_ok   <= r_legal && in_range(r_word_nxt);
            end
        end
    end

    axi_mem_dpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_hs && w_beat_ok),
        .wbe   (wstrb),
        .waddr (w_word[IDX_W-1:0]),
        .wdata (wdata),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_q)
    );

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: bursts, strobes, errors, backpressure
// and mid-burst reset, all against hand-computed expected values.
module tb_axi_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awid = '0, arid = '0, bid, rid;
    logic [31:0] awaddr = '0, araddr = '0;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [2:0]  awsize = 3'd3, arsize = 3'd3;
    logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
    logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
    logic        arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid, rlast;
    logic [63:0] wdata = '0, rdata;
    logic [7:0]  wstrb = '0;

    logic [63:0] wd [8];
    logic [7:0]  ws [8];
    logic [63:0] ed [8];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi_mem_responder dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return awready;
            1:       return wready;
            2:       return bvalid;
            3:       return arready;
            default: return rvalid;
        endcase
    endfunction

    task automatic wait_for(input int which, input string tag);
        int n = 0;
        while (!sel(which) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int last_beat, input int bdelay,
                            input logic [1:0] exp_resp, input string tag);
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd3; awvalid = 1'b1;
        wait_for(0, {tag, "_aw"});
        @(negedge clk);
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wdata = wd[b]; wstrb = ws[b]; wlast = (b == last_beat); wvalid = 1'b1;
            wait_for(1, {tag, "_w"});
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        check({tag, "_bvalid_lat"}, bvalid, 1);
        for (int i = 0; i < bdelay; i++) begin
            @(negedge clk);
            check({tag, "_bvalid_hold"}, bvalid, 1);
            check({tag, "_bid_hold"}, bid, id);
        end
        check({tag, "_bresp"}, bresp, exp_resp);
        check({tag, "_bid"}, bid, id);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check({tag, "_aw_again"}, awready, 1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input bit toggle, input logic [1:0] exp_resp,
                           input string tag);
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd3; arvalid = 1'b1;
        wait_for(3, {tag, "_ar"});
        @(negedge clk);
        arvalid = 1'b0;
        check({tag, "_rvalid_lat"}, rvalid, 1);
        for (int b = 0; b <= int'(len); b++) begin
            if (toggle) begin
                rready = 1'b0;
                check({tag, "_rdata_pre_stall"}, rdata, ed[b]);
                @(negedge clk);
            end
            rready = 1'b1;
            check({tag, "_rvalid"}, rvalid, 1);
            check({tag, "_rdata"}, rdata, ed[b]);
            check({tag, "_rresp"}, rresp, exp_resp);
            check({tag, "_rlast"}, rlast, (b == int'(len)));
            check({tag, "_rid"}, rid, id);
            @(negedge clk);
        end
        rready = 1'b0;
        check({tag, "_rdone"}, rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            ws[i] = 8'hFF;
            wd[i] = '0;
            ed[i] = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_arready", arready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_bid", bid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_rid", rid, 0);
        check("rst_rresp", rresp, 0);
        check("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_awready", awready, 1);
        check("post_rst_arready", arready, 1);

        // INCR write and read back
        wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
        do_write(4'd1, 32'h40, 8'd3, 2'b01, 3, 0, 2'b00, "incr_wr");
        ed[0] = 64'h11; ed[1] = 64'h22; ed[2] = 64'h33; ed[3] = 64'h44;
        do_read(4'd2, 32'h40, 8'd3, 2'b01, 1'b0, 2'b00, "incr_rd");

        // Byte strobes
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        do_write(4'd1, 32'h0, 8'd0, 2'b01, 0, 0, 2'b00, "strb_full");
        wd[0] = 64'h0; ws[0] = 8'h0F;
        do_write(4'd1, 32'h0, 8'd0, 2'b01, 0, 0, 2'b00, "strb_low");
        ws[0] = 8'hFF;
        ed[0] = 64'hFFFF_FFFF_0000_0000;
        do_read(4'd3, 32'h0, 8'd0, 2'b01, 1'b0, 2'b00, "strb_rd");

        // FIXED burst keeps the last beat
        wd[0] = 64'hA; wd[1] = 64'hB; wd[2] = 64'hC;
        do_write(4'd4, 32'h8, 8'd2, 2'b00, 2, 0, 2'b00, "fixed_wr");
        ed[0] = 64'hC;
        do_read(4'd4, 32'h8, 8'd0, 2'b01, 1'b0, 2'b00, "fixed_rd");

        // Out of range write: SLVERR, word 0 (its aliased index) unchanged
        wd[0] = 64'hDEAD_BEEF_DEAD_BEEF;
        do_write(4'd6, 32'h800, 8'd0, 2'b01, 0, 0, 2'b10, "oor_wr");
        ed[0] = 64'hFFFF_FFFF_0000_0000;
        do_read(4'd6, 32'h0, 8'd0, 2'b01, 1'b0, 2'b00, "oor_rd");

        // WRAP read: two zero beats with SLVERR
        ed[0] = 64'h0; ed[1] = 64'h0;
        do_read(4'd7, 32'h40, 8'd1, 2'b10, 1'b0, 2'b10, "wrap_rd");

        // Early wlast: all 4 beats accepted, SLVERR, data still written
        wd[0] = 64'h1; wd[1] = 64'h2; wd[2] = 64'h3; wd[3] = 64'h4;
        do_write(4'd3, 32'h100, 8'd3, 2'b01, 0, 0, 2'b10, "early_last_wr");
        ed[0] = 64'h1; ed[1] = 64'h2; ed[2] = 64'h3; ed[3] = 64'h4;
        do_read(4'd3, 32'h100, 8'd3, 2'b01, 1'b0, 2'b00, "early_last_rd");

        // 8-beat read with rready toggling
        for (int i = 0; i < 8; i++) begin
            wd[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
            ed[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        end
        do_write(4'd8, 32'h200, 8'd7, 2'b01, 7, 0, 2'b00, "bp_wr");
        do_read(4'd8, 32'h200, 8'd7, 2'b01, 1'b1, 2'b00, "bp_rd");

        // bready held low for 5 cycles
        wd[0] = 64'h77;
        do_write(4'd9, 32'h300, 8'd0, 2'b01, 0, 5, 2'b00, "bhold_wr");

        // Reset asserted mid-read
        @(negedge clk);
        arid = 4'd5; araddr = 32'h200; arlen = 8'd7; arburst = 2'b01; arvalid = 1'b1;
        wait_for(3, "mid_rst_ar");
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        @(negedge clk);
        check("mid_rst_pre_rvalid", rvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_rdata", rdata, 0);
        check("mid_rst_rid", rid, 0);
        check("mid_rst_arready", arready, 0);
        rready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_arready_back", arready, 1);
        check("mid_rst_rvalid_idle", rvalid, 0);
        ed[0] = 64'h11; ed[1] = 64'h22;
        do_read(4'd1, 32'h40, 8'd1, 2'b01, 1'b0, 2'b00, "after_rst_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
